// File: rtl/keypad_emulator_if.sv
// Request handshake, matrix column/row wires and status of the keypad emulator.
// The scanner/test side uses the master modport; the emulator uses slave.
interface keypad_emulator_if;
    logic       req_valid;
    logic [3:0] req_key;
    logic       req_ready;
    logic [3:0] COLLUMMN;
    logic [3:0] LINE;
    logic       busy;
    logic       done;
    logic [7:0] press_cnt;

    modport master (
        output req_valid, req_key, COLLUMMN,
        input  req_ready, LINE, busy, done, press_cnt
    );

    modport slave (
        input  req_valid, req_key, COLLUMMN,
        output req_ready, LINE, busy, done, press_cnt
    );
endinterface

// File: rtl/keypad_emulator.sv
// Emulates one contact of a 4x4 matrix keypad pressed by request: bounce, hold, bounce, gap.
// Define KEYPAD_BOUNCE_EN to enable contact bounce; otherwise each bounce phase is one steady cycle.
module keypad_emulator #(
    parameter int unsigned HOLD_TICKS   = 2500000,
    parameter int unsigned GAP_TICKS    = 1000000,
    parameter int unsigned BOUNCE_TICKS = 5000,
    parameter int unsigned BOUNCE_EDGES = 6
) (
    input  logic               clk,
    input  logic               rst,
    keypad_emulator_if.slave   kp
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned TIMER_MAX = max2(max2(HOLD_TICKS, GAP_TICKS), max2(BOUNCE_TICKS, BOUNCE_EDGES));
    localparam int unsigned TIMER_W   = $clog2(TIMER_MAX + 1);
    localparam logic [TIMER_W-1:0] HOLD_LAST = TIMER_W'(HOLD_TICKS - 1);
    localparam logic [TIMER_W-1:0] GAP_LAST  = TIMER_W'(GAP_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS_BOUNCE,
        S_HOLD,
        S_RELEASE_BOUNCE,
        S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               contact_q, contact_d;
    logic [1:0]         row_q, row_d;
    logic [1:0]         col_q, col_d;
    logic               done_q, done_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               bounce_tick;
    logic               bounce_last;
    logic               ready;
    logic [3:0]         line_sense;

    // Returns {row, col} of the key in the matrix.
    function automatic logic [3:0] key_pos(input logic [3:0] key);
        case (key)
            4'd1:    key_pos = 4'b00_00;
            4'd2:    key_pos = 4'b00_01;
            4'd3:    key_pos = 4'b00_10;
            4'd10:   key_pos = 4'b00_11;
            4'd4:    key_pos = 4'b01_00;
            4'd5:    key_pos = 4'b01_01;
            4'd6:    key_pos = 4'b01_10;
            4'd11:   key_pos = 4'b01_11;
            4'd7:    key_pos = 4'b10_00;
            4'd8:    key_pos = 4'b10_01;
            4'd9:    key_pos = 4'b10_10;
            4'd12:   key_pos = 4'b10_11;
            4'd15:   key_pos = 4'b11_00;
            4'd0:    key_pos = 4'b11_01;
            4'd14:   key_pos = 4'b11_10;
            default: key_pos = 4'b11_11;
        endcase
    endfunction

`ifdef KEYPAD_BOUNCE_EN
    localparam logic [TIMER_W-1:0] BT_LAST    = TIMER_W'(BOUNCE_TICKS - 1);
    localparam logic [TIMER_W-1:0] EDGES_LAST = TIMER_W'(BOUNCE_EDGES - 1);

    logic [TIMER_W-1:0] edges_q, edges_d;

    assign bounce_tick = (timer_q == BT_LAST);
    assign bounce_last = bounce_tick && (edges_q == EDGES_LAST);

    // Edge count returns to zero on leaving a bounce phase, so it is always fresh on entry.
    always_comb begin
        edges_d = edges_q;
        if ((state_q == S_PRESS_BOUNCE || state_q == S_RELEASE_BOUNCE) && bounce_tick) begin
            edges_d = bounce_last ? '0 : edges_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edges_q <= '0;
        end else begin
            edges_q <= edges_d;
        end
    end
`else
    assign bounce_tick = 1'b0;
    assign bounce_last = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + 1'b1;
        contact_d = contact_q;
        row_d     = row_q;
        col_d     = col_q;
        done_d    = 1'b0;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (kp.req_valid) begin
                    state_d        = S_PRESS_BOUNCE;
                    contact_d      = 1'b1;
                    {row_d, col_d} = key_pos(kp.req_key);
                end
            end
            S_PRESS_BOUNCE: begin
                if (bounce_tick) begin
                    timer_d   = '0;
                    contact_d = ~contact_q;
                end
                if (bounce_last) begin
                    state_d = S_HOLD;
                    timer_d = '0;
                end
            end
            S_HOLD: begin
                if (timer_q == HOLD_LAST) begin
                    state_d   = S_RELEASE_BOUNCE;
                    timer_d   = '0;
                    contact_d = 1'b0;
                end
            end
            S_RELEASE_BOUNCE: begin
                if (bounce_tick) begin
                    timer_d   = '0;
                    contact_d = ~contact_q;
                end
                if (bounce_last) begin
                    state_d = S_GAP;
                    timer_d = '0;
                end
            end
            S_GAP: begin
                if (timer_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                    done_d  = 1'b1;
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            contact_q <= 1'b0;
            row_q     <= 2'd0;
            col_q     <= 2'd0;
            done_q    <= 1'b0;
            cnt_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            contact_q <= contact_d;
            row_q     <= row_d;
            col_q     <= col_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
        end
    end

    // Wired-matrix behaviour: the closed contact shorts the driven column onto its row.
    always_comb begin
        line_sense = 4'hF;
        if (contact_q && kp.COLLUMMN[col_q]) begin
            line_sense[row_q] = 1'b0;
        end
    end

    assign ready        = (state_q == S_IDLE);
    assign kp.req_ready = ready;
    assign kp.busy      = ~ready;
    assign kp.LINE      = line_sense;
    assign kp.done      = done_q;
    assign kp.press_cnt = cnt_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator: reset, per-cycle contact traces, scanning, back-to-back, wrap.
// Expected contact traces follow the KEYPAD_BOUNCE_EN setting of the build.
module tb_keypad_emulator;

`ifdef KEYPAD_BOUNCE_EN
    localparam int          LEN    = 28;
    localparam int          PB_LEN = 8;
    // press bounce, hold, release bounce, gap (1 = contact closed)
    localparam logic [27:0] PAT    = 28'b11001100_11111111_00110011_0000;
`else
    localparam int          LEN    = 14;
    localparam int          PB_LEN = 1;
    localparam logic [27:0] PAT    = {14'b1_11111111_0_0000, 14'b0};
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] exp_cnt;
    int         checks   = 0;
    int         failures = 0;

    keypad_emulator_if kp ();

    keypad_emulator #(
        .HOLD_TICKS   (8),
        .GAP_TICKS    (4),
        .BOUNCE_TICKS (2),
        .BOUNCE_EDGES (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in the first cycle after acceptance; ends in the cycle where done should be high.
    task automatic run_trace(input string tag, input logic [3:0] key_col,
                             input logic [3:0] low_line, input bit scan);
        logic [27:0] pat_v;
        logic [3:0]  oh;
        logic [3:0]  exp_line;
        pat_v = PAT;
        for (int c = 0; c < LEN; c++) begin
            if (scan) begin
                for (int k = 0; k < 4; k++) begin
                    oh = 4'(1 << k);
                    kp.COLLUMMN = oh;
                    #1;
                    exp_line = (pat_v[27-c] && (oh == key_col)) ? low_line : 4'hF;
                    check({tag, "_line"}, kp.LINE, exp_line);
                end
            end else begin
                kp.COLLUMMN = key_col;
                #1;
                exp_line = pat_v[27-c] ? low_line : 4'hF;
                check({tag, "_line"}, kp.LINE, exp_line);
            end
            check({tag, "_busy"}, kp.busy, 1'b1);
            check({tag, "_early_done"}, kp.done, 1'b0);
            tick();
        end
        exp_cnt++;
        check({tag, "_done"}, kp.done, 1'b1);
        check({tag, "_cnt"}, kp.press_cnt, exp_cnt);
        check({tag, "_ready"}, kp.req_ready, 1'b1);
    endtask

    initial begin
        int n;
        rst          = 1'b1;
        kp.req_valid = 1'b0;
        kp.req_key   = 4'd0;
        kp.COLLUMMN  = 4'hF;
        exp_cnt      = 8'd0;
        repeat (2) tick();
        check("rst_line",  kp.LINE, 4'hF);
        check("rst_ready", kp.req_ready, 1'b1);
        check("rst_busy",  kp.busy, 1'b0);
        check("rst_done",  kp.done, 1'b0);
        check("rst_cnt",   kp.press_cnt, 8'd0);
        rst = 1'b0;
        tick();

        // Reset in the middle of HOLD releases the key at once.
        kp.COLLUMMN  = 4'b0010;
        kp.req_key   = 4'd5;
        kp.req_valid = 1'b1;
        tick();
        kp.req_valid = 1'b0;
        repeat (PB_LEN + 3) tick();
        check("hold_line", kp.LINE, 4'b1101);
        rst = 1'b1;
        #1;
        check("midrst_line",  kp.LINE, 4'hF);
        check("midrst_busy",  kp.busy, 1'b0);
        check("midrst_ready", kp.req_ready, 1'b1);
        check("midrst_done",  kp.done, 1'b0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            check("midrst_nodone", kp.done, 1'b0);
            check("midrst_idle",   kp.busy, 1'b0);
        end
        check("midrst_cnt", kp.press_cnt, exp_cnt);

        // Key 5 with column 1 driven steadily; key code changes after acceptance.
        kp.req_key   = 4'd5;
        kp.COLLUMMN  = 4'b0010;
        kp.req_valid = 1'b1;
        tick();
        kp.req_valid = 1'b0;
        kp.req_key   = 4'd0;
        run_trace("key5", 4'b0010, 4'b1101, 1'b0);
        tick();
        check("done_width", kp.done, 1'b0);

        // Key * while the scanner walks the columns within each cycle.
        kp.req_key   = 4'd15;
        kp.req_valid = 1'b1;
        tick();
        kp.req_valid = 1'b0;
        run_trace("keystar", 4'b0001, 4'b0111, 1'b1);
        tick();

        // Key 8, then a key D request held through the whole sequence.
        kp.req_key   = 4'd8;
        kp.req_valid = 1'b1;
        tick();
        kp.req_key   = 4'd13;
        run_trace("key8", 4'b0010, 4'b1011, 1'b0);
        tick();
        kp.req_valid = 1'b0;
        run_trace("keyD", 4'b1000, 4'b0111, 1'b0);

        // Back-to-back presses until the counter wraps.
        kp.req_key   = 4'd1;
        kp.COLLUMMN  = 4'b0001;
        kp.req_valid = 1'b1;
        for (int p = 0; p < 252; p++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (kp.done !== 1'b1 && n < 200);
            exp_cnt++;
            check("b2b_latency", n, LEN + 1);
            check("b2b_cnt", kp.press_cnt, exp_cnt);
        end
        check("wrap_zero", kp.press_cnt, 8'd0);
        kp.req_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_emulator.md
KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

Interface
REQ-001 Parameter HOLD_TICKS, default 2500000, closed-contact hold time in clk cycles, legal range >=1.
REQ-002 Parameter GAP_TICKS, default 1000000, open-contact gap after release before the next request, legal range >=1.
REQ-003 Parameter BOUNCE_TICKS, default 5000, clk cycles per bounce half-period, legal range >=1.
REQ-004 Parameter BOUNCE_EDGES, default 6, contact toggles per bounce phase, even, legal range >=2.
REQ-005 clk  input  1  system clock; one clock domain only.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 req_valid  input  1  press request is valid.
REQ-008 req_key  input  4  key code: 0-9 digits, 10=A, 11=B, 12=C, 13=D, 14=#, 15=*.
REQ-009 req_ready  output  1  emulator accepts a request this cycle.
REQ-010 COLLUMMN  input  4  column drive from the scanner, active-high.
REQ-011 LINE  output  4  row sense to the scanner, active-low, idle 4'hF.
REQ-012 busy  output  1  press sequence in progress.
REQ-013 done  output  1  one-cycle pulse at sequence end.
REQ-014 press_cnt  output  8  count of completed presses, wraps 255->0.

Function
REQ-015 Key map (row,col): 1=(0,0) 2=(0,1) 3=(0,2) A=(0,3); 4=(1,0) 5=(1,1) 6=(1,2) B=(1,3); 7=(2,0) 8=(2,1) 9=(2,2) C=(2,3); *=(3,0) 0=(3,1) #=(3,2) D=(3,3).
REQ-016 LINE[r] SHALL be 0 only when the registered contact is closed, r equals the latched row, and COLLUMMN[latched col] is 1; every other LINE bit SHALL be 1.
REQ-017 The path from COLLUMMN to LINE SHALL be combinational with zero latency, like a wired matrix.
REQ-018 States SHALL be IDLE, PRESS_BOUNCE, HOLD, RELEASE_BOUNCE and GAP.
REQ-019 req_ready SHALL be 1 only in IDLE; busy SHALL equal ~req_ready.
REQ-020 A request SHALL be accepted when req_valid and req_ready are both 1 in the same cycle; req_key SHALL be latched on that edge; the next state SHALL be PRESS_BOUNCE.
REQ-021 In PRESS_BOUNCE the contact SHALL start closed and toggle every BOUNCE_TICKS cycles until BOUNCE_EDGES toggles have occurred; the contact SHALL then be closed; the next state SHALL be HOLD.
REQ-022 In HOLD the contact SHALL stay closed for exactly HOLD_TICKS cycles; the next state SHALL be RELEASE_BOUNCE.
REQ-023 In RELEASE_BOUNCE the contact SHALL start open and toggle as in REQ-021; it SHALL end open; the next state SHALL be GAP.
REQ-024 In GAP the contact SHALL stay open for GAP_TICKS cycles; the state SHALL then return to IDLE.
REQ-025 On the GAP->IDLE edge, done SHALL pulse for 1 cycle and press_cnt SHALL increment.
REQ-026 req_valid SHALL be ignored whenever the state is not IDLE; req_key changes after acceptance SHALL not affect the sequence.
REQ-027 A request presented in the cycle done pulses SHALL be accepted on the following cycle, with no lost cycle beyond that one.
REQ-028 Timer counters SHALL be wide enough for max(HOLD_TICKS, GAP_TICKS) and SHALL clear on every state change.

Reset
REQ-029 When rst is asserted, the state SHALL be IDLE, the contact open, LINE=4'hF, req_ready=1, busy=0, done=0, press_cnt=0 and the timers 0, all asynchronously.
REQ-030 Assertion of rst mid-sequence SHALL release the key immediately; no done pulse SHALL be produced and press_cnt SHALL not change.

Configuration
REQ-031 When macro KEYPAD_BOUNCE_EN is defined, the bounce phases SHALL behave per REQ-021 and REQ-023.
REQ-032 When KEYPAD_BOUNCE_EN is undefined, PRESS_BOUNCE and RELEASE_BOUNCE SHALL last exactly 1 cycle each with the contact steady (closed, then open); BOUNCE_TICKS and BOUNCE_EDGES SHALL then be unused.

Verification (HOLD_TICKS=8, GAP_TICKS=4, BOUNCE_TICKS=2, BOUNCE_EDGES=4, KEYPAD_BOUNCE_EN defined unless stated)
REQ-033 Request key 5 with COLLUMMN=4'b0010 held -> LINE=4'b1101 while the contact is closed; LINE=4'hF otherwise; done pulses once; press_cnt=1.
REQ-034 Request key 15 (*) while COLLUMMN scans one-hot 0001,0010,0100,1000 -> LINE=4'b0111 only during the 0001 phase with the contact closed.
REQ-035 Bounce: exactly 4 LINE transitions in each bounce phase, 2 cycles apart; LINE held low for 8 cycles in HOLD.
REQ-036 Second request held during busy, then back-to-back key 13 (D) -> it is ignored until IDLE; then accepted the cycle after done; LINE=4'b0111 with COLLUMMN=4'b1000.
REQ-037 rst pulse during HOLD -> LINE=4'hF the same cycle, no done pulse, press_cnt unchanged; 256 presses -> press_cnt wraps to 0.
REQ-038 KEYPAD_BOUNCE_EN undefined -> zero intra-phase toggles; the sequence runs 1+8+1+4 cycles from acceptance to done.
